// File: rtl/fp_addsub_arbiter_pkg.sv
// rtl/fp_addsub_arbiter_pkg.sv - shared types and rounding-mode helpers for the FADD/FSUB arbiter
package fp_arb_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } rm_e;

  localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;

  typedef struct packed {
    logic v;
    logic id;
    logic illegal;
  } tag_t;

  typedef struct packed {
    logic [31:0] result;
    logic        illegal;
  } rsp_t;

  function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == DYN) ? frm : rm;
  endfunction

  function automatic logic rm_illegal(input logic [2:0] rm_eff);
    return rm_eff > RMM;
  endfunction

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// rtl/fp_addsub_arbiter_if.sv - requester, response and datapath signals of fp_addsub_arbiter
interface fp_addsub_arbiter_if;
  logic        req0_valid_i, req0_ready_o, req0_sub_i;
  logic [31:0] req0_a_i, req0_b_i;
  logic [2:0]  req0_rm_i;
  logic        req1_valid_i, req1_ready_o, req1_sub_i;
  logic [31:0] req1_a_i, req1_b_i;
  logic [2:0]  req1_rm_i;
  logic        rsp0_valid_o, rsp0_ready_i, rsp0_illegal_o;
  logic [31:0] rsp0_result_o;
  logic        rsp1_valid_o, rsp1_ready_i, rsp1_illegal_o;
  logic [31:0] rsp1_result_o;
  logic        dp_valid_o, dp_sub_o;
  logic [31:0] dp_a_o, dp_b_o, dp_res_i;
  logic [2:0]  dp_rm_o;

  modport slave (
    input  req0_valid_i, req0_a_i, req0_b_i, req0_sub_i, req0_rm_i,
           req1_valid_i, req1_a_i, req1_b_i, req1_sub_i, req1_rm_i,
           rsp0_ready_i, rsp1_ready_i, dp_res_i,
    output req0_ready_o, req1_ready_o,
           rsp0_valid_o, rsp0_result_o, rsp0_illegal_o,
           rsp1_valid_o, rsp1_result_o, rsp1_illegal_o,
           dp_valid_o, dp_a_o, dp_b_o, dp_sub_o, dp_rm_o
  );

  modport master (
    output req0_valid_i, req0_a_i, req0_b_i, req0_sub_i, req0_rm_i,
           req1_valid_i, req1_a_i, req1_b_i, req1_sub_i, req1_rm_i,
           rsp0_ready_i, rsp1_ready_i, dp_res_i,
    input  req0_ready_o, req1_ready_o,
           rsp0_valid_o, rsp0_result_o, rsp0_illegal_o,
           rsp1_valid_o, rsp1_result_o, rsp1_illegal_o,
           dp_valid_o, dp_a_o, dp_b_o, dp_sub_o, dp_rm_o
  );
endinterface

// File: rtl/fp_addsub_arbiter_rsp_fifo.sv
// rtl/fp_addsub_arbiter_rsp_fifo.sv - per-requester response FIFO with registered head and sync clear
module fp_rsp_fifo
  import fp_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  rsp_t                   push_data,
  input  logic                   pop,
  output rsp_t                   head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rsp_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  // Head comes straight from storage, so a push is never visible in the same cycle.
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !clear));

endmodule

// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - round-robin sharing of one fixed-latency FADD/FSUB datapath by two requesters
module fp_addsub_arbiter
  import fp_arb_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush_i,
  input  logic [2:0]                frm_i,
  fp_addsub_arbiter_if.slave        bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    req_valid, req_sub, rsp_ready, elig, grant, push, empty;
  logic [31:0]   req_a [2];
  logic [31:0]   req_b [2];
  logic [2:0]    req_rm [2];
  rsp_t          head [2];
  logic [CW-1:0] count [2];
  int            inflight [2];
  tag_t          pipe [LATENCY];
  tag_t          tag_out;
  rsp_t          push_data;
  logic          rr_ptr, win, any_grant, win_illegal;
  logic [2:0]    rm_eff;

  assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
  assign req_sub   = {bus.req1_sub_i, bus.req0_sub_i};
  assign rsp_ready = {bus.rsp1_ready_i, bus.rsp0_ready_i};
  assign req_a[0]  = bus.req0_a_i;
  assign req_a[1]  = bus.req1_a_i;
  assign req_b[0]  = bus.req0_b_i;
  assign req_b[1]  = bus.req1_b_i;
  assign req_rm[0] = bus.req0_rm_i;
  assign req_rm[1] = bus.req1_rm_i;

  always_comb begin
    inflight[0] = 0;
    inflight[1] = 0;
    for (int i = 0; i < LATENCY; i++) begin
      if (pipe[i].v) begin
        if (pipe[i].id) inflight[1]++;
        else            inflight[0]++;
      end
    end
  end

  // Credit counts ops still in the pipe plus buffered results; a pop this cycle is not credited yet.
  always_comb begin
    for (int n = 0; n < 2; n++)
      elig[n] = reset_n & req_valid[n] & ~flush_i & ((inflight[n] + int'(count[n])) < FIFO_DEPTH);
    grant = 2'b00;
    if (elig == 2'b11) grant[rr_ptr] = 1'b1;
    else               grant = elig;
  end

  assign any_grant   = |grant;
  assign win         = grant[1];
  assign rm_eff      = resolve_rm(req_rm[win], frm_i);
  assign win_illegal = rm_illegal(rm_eff);

  assign bus.req0_ready_o = grant[0];
  assign bus.req1_ready_o = grant[1];
  assign bus.dp_valid_o   = any_grant;
  assign bus.dp_a_o       = any_grant ? req_a[win] : '0;
  assign bus.dp_b_o       = any_grant ? req_b[win] : '0;
  assign bus.dp_sub_o     = any_grant & req_sub[win];
  assign bus.dp_rm_o      = (any_grant && !win_illegal) ? rm_eff : RNE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      if (elig == 2'b11) rr_ptr <= ~rr_ptr;
      pipe[0] <= '{v: any_grant, id: win, illegal: any_grant & win_illegal};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= flush_i ? '0 : pipe[i-1];
    end
  end

  assign tag_out   = pipe[LATENCY-1];
  assign push_data = '{result: (tag_out.illegal ? CANON_NAN : bus.dp_res_i), illegal: tag_out.illegal};
  assign push[0]   = tag_out.v & ~tag_out.id & ~flush_i;
  assign push[1]   = tag_out.v &  tag_out.id & ~flush_i;

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    fp_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset_n),
      .clear     (flush_i),
      .push      (push[n]),
      .push_data (push_data),
      .pop       (rsp_ready[n]),
      .head      (head[n]),
      .empty     (empty[n]),
      .count     (count[n])
    );
  end

  assign bus.rsp0_valid_o   = ~empty[0];
  assign bus.rsp0_result_o  = head[0].result;
  assign bus.rsp0_illegal_o = head[0].illegal;
  assign bus.rsp1_valid_o   = ~empty[1];
  assign bus.rsp1_result_o  = head[1].result;
  assign bus.rsp1_illegal_o = head[1].illegal;

endmodule
